cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shares the single burst-memory port between the instruction cache and the data cache. Accepts full-line (256-bit) read requests from both caches and line write-backs from the data cache. Sequences each line as four 64-bit bursts on the memory side and returns one single-cycle response to the granted cache. Sits between the two caches' downward-facing ports and the top-level memory model/controller.

## Interface
Parameters:
- None. Line width (256), beat width (64) and burst length (4) are package constants.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_dfp_addr  in  32  I-cache line address; bits [4:0] ignored.
- i_dfp_read  in  1  I-cache line read request; level, held until i_dfp_resp.
- i_dfp_rdata  out  256  line returned to I-cache.
- i_dfp_resp  out  1  one-cycle completion pulse to I-cache.
- d_dfp_addr  in  32  D-cache line address; bits [4:0] ignored.
- d_dfp_read  in  1  D-cache line read request; level.
- d_dfp_write  in  1  D-cache line write-back request; level.
- d_dfp_wdata  in  256  write-back line.
- d_dfp_rdata  out  256  line returned to D-cache.
- d_dfp_resp  out  1  one-cycle completion pulse to D-cache.
- bmem_addr  out  32  line-aligned burst address.
- bmem_read  out  1  burst read command.
- bmem_write  out  1  burst write beat valid.
- bmem_wdata  out  64  write beat.
- bmem_ready  in  1  memory accepts command/beat this cycle.
- bmem_raddr  in  32  address tag of returning read beat.
- bmem_rdata  in  64  read beat.
- bmem_rvalid  in  1  read beat valid.

## Operation
- States: IDLE, RD_CMD, RD_COLLECT, WR_BURST, RESP.
- IDLE: if any request is present, latch the requester, the line-aligned address ({addr[31:5],5'b0}) and, for writes, wdata. Go to RD_CMD (read) or WR_BURST (write).
- Arbitration applies only in IDLE. While a transaction is outstanding, new or changed requests are ignored.
- D-cache with both read and write asserted: write wins (illegal input; the bench flags it).
- RD_CMD: bmem_read=1 and bmem_addr=latched address until bmem_ready. Then go to RD_COLLECT with beat counter 0.
- RD_COLLECT: on bmem_rvalid with bmem_raddr equal to the latched address, store beat k into line bits [64k+63:64k] and increment k. Beats with a mismatched raddr are dropped. After beat 3, go to RESP.
- WR_BURST: bmem_write=1, bmem_addr=latched address, bmem_wdata=latched line bits [64k+63:64k]. Counter k advances on each cycle with bmem_ready. After beat 3 is accepted, go to RESP.
- RESP: pulse the granted cache's resp for one cycle; rdata is the assembled line (writes: rdata undefined, resp only). Then go to IDLE.
- A requester that drops its request mid-transaction still gets the transaction completed and its resp pulsed.
- The non-granted cache's resp stays 0 throughout.

## Timing
- Reset: state IDLE, counter 0, all outputs 0 (resps, rdata, bmem_read/write/addr/wdata); line buffer cleared; last-grant = I-cache.
- Reset mid-transaction aborts immediately. Beats already received are discarded and no resp is issued.
- Read latency: request seen in IDLE at cycle n; bmem_read at n+1. Resp comes 1 cycle after the 4th accepted beat.
- Write latency: beats start at n+1; with bmem_ready held high, resp at n+5.
- Back-to-back: at least one IDLE cycle between transactions.
- rdata is held stable from RESP until the next transaction's RESP.
- Memory-side outputs are driven combinationally from state and registered data only; no combinational path from cache inputs to bmem outputs.

## Configuration
- CACHE_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not granted last. Last-grant updates on each grant and resets to I-cache, so the first tie goes to D-cache.
- Not defined: fixed priority, D-cache always wins ties. Last-grant register is absent.

## Structure
- Package cache_arb_pkg: arb_state_t enum, requester_t enum (REQ_I, REQ_D), LINE_W=256, BEAT_W=64, BURST_LEN=4.
- One sub-module, line_beat_buffer: 256-bit line register with a 2-bit beat counter. It supports beat-write (deserialize) and beat-select (serialize), plus clear and done flag.

## Test plan
- I-cache read 0x0000_1234, memory returns beats 0x11…,0x22…,0x33…,0x44… -> bmem_addr 0x0000_1220; i_dfp_resp one pulse; i_dfp_rdata={0x44..,0x33..,0x22..,0x11..}.
- D-cache write 0x8000_0040, wdata words W0..W3, bmem_ready stuck high -> bmem_write 4 consecutive cycles with W0..W3 in order; d_dfp_resp at n+5.
- Simultaneous I read and D read from reset -> D granted first. With the macro, the next tie goes to I; without it, D again.
- bmem_ready low for 3 cycles during the write burst -> the beat is held, with no skips or duplicates.
- Stray rvalid beat with raddr 0xDEAD_0000 interleaved in a read -> beat dropped; line correct.
- rst asserted after 2 read beats -> outputs 0 next cycle, no resp; a subsequent read completes correctly.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// -----------------------------------------------------------------------------
// cache_arb_pkg
//
// Shared types and constants for the cache-to-memory arbiter.
//   - arb_state_t : arbiter transaction states
//   - requester_t : which cache owns the current transaction
//   - LINE_W / BEAT_W / BURST_LEN : one 256-bit cache line moves as four
//     64-bit memory beats
//   - line_align() : clears the byte-within-line offset of an address
// -----------------------------------------------------------------------------
package cache_arb_pkg;

  localparam int LINE_W     = 256;
  localparam int BEAT_W     = 64;
  localparam int BURST_LEN  = 4;
  localparam int BEAT_IDX_W = 2;
  localparam int ADDR_W     = 32;

  // Byte offset inside a 32-byte line.
  localparam logic [ADDR_W-1:0] LINE_OFFSET_MASK = 32'h0000_001F;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_COLLECT,
    WR_BURST,
    RESP
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & ~LINE_OFFSET_MASK;
  endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// -----------------------------------------------------------------------------
// line_beat_buffer
//
// One cache line register plus a 2-bit beat index. Reads deserialize memory
// beats into the line; write-backs load the whole line and then serialize it
// beat by beat.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset (clears line/index)
//   clear          : zero the line and restart at beat 0
//   load           : load load_line and restart at beat 0
//   load_line      : full line for a write-back
//   beat_wr        : store beat_in at the current index, then advance
//   beat_in        : incoming memory beat
//   beat_adv       : advance the index without changing the line
//   line_next      : line value as it will be after this cycle's update
//   beat_out       : line slice selected by the current index
//   done           : current index is the final beat of the burst
// -----------------------------------------------------------------------------
module line_beat_buffer
  import cache_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              beat_wr,
  input  logic [BEAT_W-1:0] beat_in,
  input  logic              beat_adv,
  output logic [LINE_W-1:0] line_next,
  output logic [BEAT_W-1:0] beat_out,
  output logic              done
);

  logic [LINE_W-1:0]     line_q, line_d;
  logic [BEAT_IDX_W-1:0] idx_q, idx_d;

  // Clear and load take precedence over beat operations; the arbiter never
  // asserts them together, but the ordering keeps the behaviour defined.
  always_comb begin
    line_d = line_q;
    idx_d  = idx_q;
    if (clear) begin
      line_d = '0;
      idx_d  = '0;
    end else if (load) begin
      line_d = load_line;
      idx_d  = '0;
    end else if (beat_wr) begin
      line_d[int'(idx_q)*BEAT_W +: BEAT_W] = beat_in;
      idx_d = idx_q + BEAT_IDX_W'(1);
    end else if (beat_adv) begin
      idx_d = idx_q + BEAT_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      idx_q  <= '0;
    end else begin
      line_q <= line_d;
      idx_q  <= idx_d;
    end
  end

  // line_next lets the arbiter capture the finished line in the same cycle
  // the last beat arrives, so rdata is valid while resp is high.
  assign line_next = line_d;
  assign beat_out  = line_q[int'(idx_q)*BEAT_W +: BEAT_W];
  assign done      = (idx_q == BEAT_IDX_W'(BURST_LEN - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one burst-memory port between the I-cache and the D-cache. Each
// granted request moves a full 256-bit line as four 64-bit beats, then the
// granted cache gets a one-cycle resp pulse.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   i_dfp_addr/read          : I-cache line read request (level)
//   i_dfp_rdata/resp         : line and completion pulse back to I-cache
//   d_dfp_addr/read/write    : D-cache line read / write-back request (level)
//   d_dfp_wdata              : D-cache write-back line
//   d_dfp_rdata/resp         : line and completion pulse back to D-cache
//   bmem_addr/read/write     : memory command, line-aligned address
//   bmem_wdata               : write beat
//   bmem_ready               : memory accepts command / beat this cycle
//   bmem_raddr/rdata/rvalid  : returning read beat and its address tag
//
// Configuration:
//   CACHE_ARB_ROUND_ROBIN_EN : when defined, simultaneous requests alternate
//                              (first tie after reset goes to the D-cache).
//                              When undefined, the D-cache always wins ties.
// -----------------------------------------------------------------------------
module cache_mem_arbiter
  import cache_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_dfp_addr,
  input  logic              i_dfp_read,
  output logic [LINE_W-1:0] i_dfp_rdata,
  output logic              i_dfp_resp,
  input  logic [ADDR_W-1:0] d_dfp_addr,
  input  logic              d_dfp_read,
  input  logic              d_dfp_write,
  input  logic [LINE_W-1:0] d_dfp_wdata,
  output logic [LINE_W-1:0] d_dfp_rdata,
  output logic              d_dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  arb_state_t        state_q, state_d;
  requester_t        gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  logic              buf_clear;
  logic              buf_load;
  logic              buf_beat_wr;
  logic              buf_beat_adv;
  logic [LINE_W-1:0] buf_line_next;
  logic [BEAT_W-1:0] buf_beat_out;
  logic              buf_done;

  logic i_req;
  logic d_req;
  logic pick_d;

  assign i_req = i_dfp_read;
  assign d_req = d_dfp_read | d_dfp_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  requester_t last_q, last_d;

  // On a tie, hand the port to whoever did not get it last time.
  always_comb begin
    pick_d = d_req && (!i_req || (last_q == REQ_I));
  end

  always_comb begin
    last_d = last_q;
    if ((state_q == IDLE) && (i_req || d_req)) begin
      last_d = pick_d ? REQ_D : REQ_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_I;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: the D-cache wins every tie.
  always_comb begin
    pick_d = d_req;
  end
`endif

  // Requests are only looked at in IDLE; once a transaction is latched the
  // cache-side inputs are ignored until it finishes.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    buf_clear    = 1'b0;
    buf_load     = 1'b0;
    buf_beat_wr  = 1'b0;
    buf_beat_adv = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d  = pick_d ? REQ_D : REQ_I;
          addr_d = line_align(pick_d ? d_dfp_addr : i_dfp_addr);
          // A D-cache asserting read and write together is treated as a write.
          if (pick_d && d_dfp_write) begin
            buf_load = 1'b1;
            state_d  = WR_BURST;
          end else begin
            buf_clear = 1'b1;
            state_d   = RD_CMD;
          end
        end
      end

      RD_CMD: begin
        if (bmem_ready) begin
          state_d = RD_COLLECT;
        end
      end

      // Beats tagged with another address belong to someone else and are dropped.
      RD_COLLECT: begin
        if (bmem_rvalid && (bmem_raddr == addr_q)) begin
          buf_beat_wr = 1'b1;
          if (buf_done) begin
            state_d = RESP;
            if (gnt_q == REQ_I) begin
              i_rdata_d = buf_line_next;
            end else begin
              d_rdata_d = buf_line_next;
            end
          end
        end
      end

      WR_BURST: begin
        if (bmem_ready) begin
          buf_beat_adv = 1'b1;
          if (buf_done) begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= REQ_I;
      addr_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  line_beat_buffer u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (buf_clear),
    .load      (buf_load),
    .load_line (d_dfp_wdata),
    .beat_wr   (buf_beat_wr),
    .beat_in   (bmem_rdata),
    .beat_adv  (buf_beat_adv),
    .line_next (buf_line_next),
    .beat_out  (buf_beat_out),
    .done      (buf_done)
  );

  // Memory-side outputs depend only on state and registered data, so there
  // is no combinational path from the caches to the memory port.
  assign bmem_read  = (state_q == RD_CMD);
  assign bmem_write = (state_q == WR_BURST);
  assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? buf_beat_out : '0;

  assign i_dfp_resp  = (state_q == RESP) && (gnt_q == REQ_I);
  assign d_dfp_resp  = (state_q == RESP) && (gnt_q == REQ_D);
  assign i_dfp_rdata = i_rdata_q;
  assign d_dfp_rdata = d_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Self-checking bench for cache_mem_arbiter. A table of line transactions is
// applied in a loop; expected responses go into a scoreboard queue when a
// request is driven and are popped when the arbiter pulses resp. Arbitration
// ties and reset during a read are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

  logic         clk;
  logic         rst;
  logic [31:0]  i_dfp_addr;
  logic         i_dfp_read;
  logic [255:0] i_dfp_rdata;
  logic         i_dfp_resp;
  logic [31:0]  d_dfp_addr;
  logic         d_dfp_read;
  logic         d_dfp_write;
  logic [255:0] d_dfp_wdata;
  logic [255:0] d_dfp_rdata;
  logic         d_dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  typedef enum logic [1:0] {K_IRD, K_DRD, K_DWR, K_DRW} kind_t;

  typedef struct {
    kind_t        kind;
    logic [31:0]  addr;
    logic [31:0]  exp_addr;
    logic [255:0] line;
    bit           stray;
    bit           stall;
    bit           drop;
  } vec_t;

  typedef struct {
    bit           is_d;
    bit           is_wr;
    logic [255:0] line;
  } exp_t;

  exp_t         sbq[$];
  vec_t         vecs[7];
  int           n_cmp;
  int           n_fail;
  logic [255:0] last_i_line;
  logic [255:0] last_d_line;

  cache_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_dfp_addr  (i_dfp_addr),
    .i_dfp_read  (i_dfp_read),
    .i_dfp_rdata (i_dfp_rdata),
    .i_dfp_resp  (i_dfp_resp),
    .d_dfp_addr  (d_dfp_addr),
    .d_dfp_read  (d_dfp_read),
    .d_dfp_write (d_dfp_write),
    .d_dfp_wdata (d_dfp_wdata),
    .d_dfp_rdata (d_dfp_rdata),
    .d_dfp_resp  (d_dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the sequence.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] time limit expired");
  end

  // Move to 1 time unit after the next rising edge, where inputs are driven
  // and outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clearRequests();
    i_dfp_read  = 1'b0;
    d_dfp_read  = 1'b0;
    d_dfp_write = 1'b0;
  endtask

  task automatic doReset();
    rst         = 1'b1;
    i_dfp_addr  = '0;
    d_dfp_addr  = '0;
    d_dfp_wdata = '0;
    clearRequests();
    bmem_ready  = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    bmem_rvalid = 1'b0;
    last_i_line = '0;
    last_d_line = '0;
    sbq.delete();
    repeat (2) tick();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_resp"}, {i_dfp_resp, d_dfp_resp}, 2'b00);
    checkOutput({tag, "_bmem_cmd"}, {bmem_read, bmem_write}, 2'b00);
    checkOutput({tag, "_bmem_addr"}, bmem_addr, 32'h0);
    checkOutput({tag, "_bmem_wdata"}, bmem_wdata, 64'h0);
    checkOutput({tag, "_i_rdata"}, i_dfp_rdata, 256'h0);
    checkOutput({tag, "_d_rdata"}, d_dfp_rdata, 256'h0);
  endtask

  // Called in the cycle the arbiter should be in RESP: pops the scoreboard
  // and compares the owner and the returned line.
  task automatic popCheck();
    exp_t e;
    checkOutput("resp_seen", i_dfp_resp | d_dfp_resp, 1'b1);
    if (sbq.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL sb_empty: got resp i=%0b d=%0b required a queued transaction", i_dfp_resp, d_dfp_resp);
    end else begin
      e = sbq.pop_front();
      checkOutput("resp_owner", {i_dfp_resp, d_dfp_resp}, e.is_d ? 2'b01 : 2'b10);
      if (!e.is_wr) begin
        if (e.is_d) begin
          checkOutput("d_rdata", d_dfp_rdata, e.line);
          last_d_line = e.line;
        end else begin
          checkOutput("i_rdata", i_dfp_rdata, e.line);
          last_i_line = e.line;
        end
      end
    end
  endtask

  // Plays the memory for one read: expects the command exp_lat cycles after
  // the call, accepts it, returns four beats (optionally with a foreign beat
  // before beat 2) and ends in the RESP cycle.
  task automatic serviceRead(input logic [31:0] exp_addr, input logic [255:0] line,
                             input bit stray, input bit drop, input int exp_lat);
    int lat;
    tick();
    lat = 1;
    while ((bmem_read !== 1'b1) && (lat < 6)) begin
      tick();
      lat++;
    end
    checkOutput("rd_cmd_latency", lat, exp_lat);
    checkOutput("rd_cmd_addr", bmem_addr, exp_addr);
    if (drop) clearRequests();
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    checkOutput("rd_cmd_released", bmem_read, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        checkOutput("rdata_hold_i", i_dfp_rdata, last_i_line);
        checkOutput("rdata_hold_d", d_dfp_rdata, last_d_line);
      end
      if (stray && (k == 2)) begin
        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'hDEAD_0000;
        bmem_rdata  = 64'hBADB_ADBA_DBAD_BADB;
        tick();
      end
      bmem_rvalid = 1'b1;
      bmem_raddr  = exp_addr;
      bmem_rdata  = line[k*64 +: 64];
      tick();
    end
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    popCheck();
  endtask

  // Plays the memory for one write-back, optionally holding bmem_ready low
  // for three cycles while beat 1 is on the bus.
  task automatic serviceWrite(input logic [31:0] exp_addr, input logic [255:0] line,
                              input bit stall, input bit drop);
    int cyc;
    int stalls;
    int k;
    stalls = 0;
    k      = 0;
    tick();
    cyc = 1;
    checkOutput("wr_start", bmem_write, 1'b1);
    checkOutput("wr_addr", bmem_addr, exp_addr);
    d_dfp_wdata = '1;
    if (drop) clearRequests();
    for (int guard = 0; (guard < 16) && (k < 4); guard++) begin
      checkOutput("wr_valid", bmem_write, 1'b1);
      checkOutput("wr_beat", bmem_wdata, line[k*64 +: 64]);
      if (stall && (k == 1) && (stalls < 3)) begin
        bmem_ready = 1'b0;
        stalls++;
      end else begin
        bmem_ready = 1'b1;
        k++;
      end
      tick();
      cyc++;
    end
    bmem_ready = 1'b0;
    checkOutput("wr_resp_cycle", cyc, 5 + stalls);
    popCheck();
  endtask

  task automatic applyStimulus(input vec_t v);
    case (v.kind)
      K_IRD: begin
        i_dfp_addr = v.addr;
        i_dfp_read = 1'b1;
        sbq.push_back('{1'b0, 1'b0, v.line});
      end
      K_DRD: begin
        d_dfp_addr = v.addr;
        d_dfp_read = 1'b1;
        sbq.push_back('{1'b1, 1'b0, v.line});
      end
      K_DWR: begin
        d_dfp_addr  = v.addr;
        d_dfp_write = 1'b1;
        d_dfp_wdata = v.line;
        sbq.push_back('{1'b1, 1'b1, v.line});
      end
      default: begin
        $display("[TB] note: illegal input, D-cache read and write asserted together; write expected");
        d_dfp_addr  = v.addr;
        d_dfp_read  = 1'b1;
        d_dfp_write = 1'b1;
        d_dfp_wdata = v.line;
        sbq.push_back('{1'b1, 1'b1, v.line});
      end
    endcase
    if ((v.kind == K_DWR) || (v.kind == K_DRW)) begin
      serviceWrite(v.exp_addr, v.line, v.stall, v.drop);
    end else begin
      serviceRead(v.exp_addr, v.line, v.stray, v.drop, 1);
    end
    clearRequests();
    tick();
    checkOutput("resp_single_pulse", {i_dfp_resp, d_dfp_resp}, 2'b00);
  endtask

  logic [255:0] line_d1, line_d2, line_i1, line_r;

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{K_IRD, 32'h0000_1234, 32'h0000_1220,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{K_DWR, 32'h8000_0040, 32'h8000_0040,
                {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                 64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000}, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{K_DRD, 32'h1234_567F, 32'h1234_5660,
                {64'hD3D3_D3D3_0123_4567, 64'hD2D2_D2D2_89AB_CDEF,
                 64'hD1D1_D1D1_FEDC_BA98, 64'hD0D0_D0D0_7654_3210}, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{K_DWR, 32'h0000_0FFF, 32'h0000_0FE0,
                {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
                 64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0}, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{K_IRD, 32'hFFFF_FFE5, 32'hFFFF_FFE0,
                {64'h0000_0000_0000_0004, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0001, 64'h0123_4567_89AB_CDEF}, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{K_DRW, 32'h4000_0010, 32'h4000_0000,
                {64'hC3C3_0000_C3C3_0000, 64'hC2C2_0000_C2C2_0000,
                 64'hC1C1_0000_C1C1_0000, 64'hC0C0_0000_C0C0_0000}, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{K_DRD, 32'h0000_1220, 32'h0000_1220,
                {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
                 64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000}, 1'b0, 1'b0, 1'b0};

    line_d1 = {64'hE103, 64'hE102, 64'hE101, 64'hE100};
    line_d2 = {64'hE203, 64'hE202, 64'hE201, 64'hE200};
    line_i1 = {64'hF103, 64'hF102, 64'hF101, 64'hF100};
    line_r  = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
               64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};

    // Reset values, sampled while reset is held.
    doReset();
    checkIdleOutputs("reset");
    rst = 1'b0;

    // Simultaneous I and D reads straight out of reset: D wins the first tie.
    i_dfp_addr = 32'h0000_3008;
    i_dfp_read = 1'b1;
    d_dfp_addr = 32'h0000_5010;
    d_dfp_read = 1'b1;
    sbq.push_back('{1'b1, 1'b0, line_d1});
    serviceRead(32'h0000_5000, line_d1, 1'b0, 1'b0, 1);
    // Both still requesting when the arbiter returns to IDLE: a second tie.
    d_dfp_addr = 32'h0000_6018;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    sbq.push_back('{1'b0, 1'b0, line_i1});
    serviceRead(32'h0000_3000, line_i1, 1'b0, 1'b0, 2);
    i_dfp_read = 1'b0;
    sbq.push_back('{1'b1, 1'b0, line_d2});
    serviceRead(32'h0000_6000, line_d2, 1'b0, 1'b0, 2);
`else
    sbq.push_back('{1'b1, 1'b0, line_d2});
    serviceRead(32'h0000_6000, line_d2, 1'b0, 1'b0, 2);
    d_dfp_read = 1'b0;
    sbq.push_back('{1'b0, 1'b0, line_i1});
    serviceRead(32'h0000_3000, line_i1, 1'b0, 1'b0, 2);
`endif
    clearRequests();
    tick();
    checkOutput("tie_resp_end", {i_dfp_resp, d_dfp_resp}, 2'b00);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset in the middle of a read after two beats: everything aborts.
    i_dfp_addr = 32'h0000_2004;
    i_dfp_read = 1'b1;
    tick();
    checkOutput("abort_cmd", bmem_read, 1'b1);
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h0000_2000;
      bmem_rdata  = 64'hABAB_0000_0000_0000 | 64'(k);
      tick();
    end
    bmem_rvalid = 1'b0;
    rst = 1'b1;
    clearRequests();
    tick();
    checkIdleOutputs("abort");
    rst = 1'b0;
    last_i_line = '0;
    last_d_line = '0;
    tick();
    checkOutput("abort_no_resp", {i_dfp_resp, d_dfp_resp}, 2'b00);
    applyStimulus('{K_IRD, 32'h0000_2004, 32'h0000_2000, line_r, 1'b0, 1'b0, 1'b0});

    checkOutput("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
